// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing ahead of the control unit; holds the IR and picks the next PC.
// Latency: fetch result lands in the IR one cycle after imem_ready; min 2 cycles per instruction.
// Backpressure: waits in FETCH while imem_ready=0 and freezes EXEC while stall=1; HALT is terminal.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  // instruction memory handshake
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  // downstream pipeline control
  input  logic        stall,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic        Branch,
  input  logic        Halted,
  input  logic        zero,
  input  logic [31:0] branch_imm,
  input  logic [31:0] rs_data,
  // instruction presented to the control unit
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  // status
  output logic        retire,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_count;
  logic        r_retire;
  logic        r_halted;
  logic        r_fault;

  logic [31:0] w_link;
  logic [31:0] w_br_off;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_next_pc;
  logic        w_fetch_done;
  logic        w_exec_go;
  logic        w_commit;
  logic        w_halt_take;
  logic        w_misaligned;

  // Sequential fall-through address; also the JAL write-back value.
  assign w_link     = r_pc + 32'd4;
  // Immediate is a word offset; the shift drops its top two bits by design.
  assign w_br_off   = branch_imm << 2;
  // Pseudo-direct jump keeps the 256 MB region of the fall-through address.
  assign w_jump_tgt = {w_link[31:28], r_instr[25:0], 2'b00};

  // Next-PC select: register jump beats direct jump beats taken branch.
  always_comb begin
    w_next_pc = w_link;
    if (Jump && JumpReg) begin
      w_next_pc = rs_data;
    end else if (Jump) begin
      w_next_pc = w_jump_tgt;
    end else if (Branch && zero) begin
      w_next_pc = w_link + w_br_off;
    end
  end

  // Decoder inputs only matter on the EXEC edge where stall is low.
  assign w_fetch_done = (r_state == S_FETCH) && imem_ready;
  assign w_exec_go    = (r_state == S_EXEC) && !stall;
  assign w_halt_take  = w_exec_go && Halted;
  assign w_commit     = w_exec_go && !Halted;
  assign w_misaligned = (w_next_pc[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a misaligned target still commits, then stops the core.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_halt_take) begin
          w_state_nxt = S_HALT;
        end else if (w_commit) begin
          w_state_nxt = w_misaligned ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Instruction register: captured only on a completed fetch handshake.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_instr <= 32'd0;
    end else if (w_fetch_done) begin
      r_instr <= imem_rdata;
    end
  end

  // PC and retire counter advance together on commit; the count wraps naturally.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_pc    <= RESET_PC;
      r_count <= 32'd0;
    end else if (w_commit) begin
      r_pc    <= w_next_pc;
      r_count <= r_count + 32'd1;
    end
  end

  // Retire is a single-cycle pulse coinciding with the first FETCH cycle of the next instruction.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_retire <= 1'b0;
    end else begin
      r_retire <= w_commit;
    end
  end

  // Sticky stop flags; fault distinguishes a bad target from a decoded halt.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else if (w_halt_take) begin
      r_halted <= 1'b1;
    end else if (w_commit && w_misaligned) begin
      r_halted <= 1'b1;
      r_fault  <= 1'b1;
    end
  end

  assign imem_req      = (r_state == S_FETCH);
  assign imem_addr     = r_pc;
  assign instr         = r_instr;
  assign opcode        = r_instr[31:26];
  assign func          = r_instr[5:0];
  assign instr_valid   = (r_state == S_EXEC);
  assign pc            = r_pc;
  assign link_addr     = w_link;
  assign retire        = r_retire;
  assign halted        = r_halted;
  assign fault         = r_fault;
  assign retired_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bench plays memory and decoder, expected fetch addresses go through a queue.
// Latency: checks one fetch per 2 cycles with memory always ready.
// Backpressure: exercises memory wait, EXEC stall, halt, fault and mid-fetch reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst_b;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        Jump, JumpReg, Branch, Halted, zero;
  logic [31:0] branch_imm;
  logic [31:0] rs_data;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        retire;
  logic        halted;
  logic        fault;
  logic [31:0] retired_count;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_b(rst_b),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .stall(stall), .Jump(Jump), .JumpReg(JumpReg), .Branch(Branch), .Halted(Halted), .zero(zero),
    .branch_imm(branch_imm), .rs_data(rs_data),
    .instr(instr), .opcode(opcode), .func(func), .instr_valid(instr_valid),
    .pc(pc), .link_addr(link_addr), .retire(retire), .halted(halted), .fault(fault),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] word;
    logic        j;
    logic        jr;
    logic        br;
    logic        z;
    logic [31:0] imm;
    logic [31:0] rs;
    logic [31:0] link;
    logic [31:0] nxt;
    logic        gap;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt = 0;
  int          last_fetch = 0;
  int          rcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_dec();
    Jump = 0; JumpReg = 0; Branch = 0; Halted = 0; zero = 0;
    branch_imm = 32'd0; rs_data = 32'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'h100);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_cnt"}, retired_count, 32'd0);
    chk({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_addr"}, imem_addr, 32'h100);
    chk({tag, "_flags"}, {instr_valid, retire, halted, fault}, 4'b0000);
  endtask

  // Wait for a fetch request, compare its address against the scoreboard, answer it.
  task automatic fetch(input logic [31:0] word, input logic chk_gap);
    logic [31:0] exp_addr;
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    if (!imem_req) begin
      n_tests++; n_fail++;
      $display("FAIL fetch_timeout: got req=0 expected req=1");
      return;
    end
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL fetch_unexpected: got addr %h expected no request", imem_addr);
      exp_addr = 32'hxxxx_xxxx;
    end else begin
      exp_addr = sb.pop_front();
      chk("fetch_addr", imem_addr, exp_addr);
    end
    if (chk_gap) chk("fetch_gap", cyc - last_fetch, 2);
    last_fetch = cyc;
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    chk("exec_valid", instr_valid, 1'b1);
    chk("exec_instr", instr, word);
    chk("exec_opcode", opcode, word[31:26]);
    chk("exec_func", func, word[5:0]);
    chk("exec_pc", pc, exp_addr);
  endtask

  // Drive the decoder for one instruction in EXEC and check the commit.
  task automatic commit(input vec_t v);
    Jump = v.j; JumpReg = v.jr; Branch = v.br; zero = v.z;
    branch_imm = v.imm; rs_data = v.rs;
    chk("link_addr", link_addr, v.link);
    sb.push_back(v.nxt);
    exp_cnt = exp_cnt + 1;
    @(negedge clk);
    clr_dec();
    chk("retire", retire, 1'b1);
    chk("retired_count", retired_count, exp_cnt);
    chk("next_pc", pc, v.nxt);
    chk("next_req", imem_req, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //        word          j  jr br z  imm            rs             link           nxt            gap
    vecs[0] = '{32'h0000_0020, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0104, 32'h0000_0104, 0};
    vecs[1] = '{32'h0000_0020, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0108, 32'h0000_0108, 1};
    vecs[2] = '{32'h0000_0020, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_010C, 32'h0000_010C, 1};
    vecs[3] = '{32'h0800_0080, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0110, 32'h0000_0200, 1};
    vecs[4] = '{32'h1000_FFFF, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0,         32'h0000_0204, 32'h0000_01F4, 1};
    vecs[5] = '{32'h0800_0080, 1, 0, 1, 1, 32'h0000_0040, 32'h0,         32'h0000_01F8, 32'h0000_0200, 1};
    vecs[6] = '{32'h1000_FFFF, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0204, 32'h0000_0204, 1};
    vecs[7] = '{32'h0020_0008, 1, 1, 0, 0, 32'h0,          32'h1000_0010, 32'h0000_0208, 32'h1000_0010, 1};
    vecs[8] = '{32'h0C00_0040, 1, 0, 0, 0, 32'h0,          32'h0,         32'h1000_0014, 32'h1000_0100, 1};
    vecs[9] = '{32'h0020_0008, 1, 1, 0, 0, 32'h0,          32'h0000_2000, 32'h1000_0104, 32'h0000_2000, 1};

    rst_b = 0; imem_ready = 1; imem_rdata = 32'hDEAD_BEEF; stall = 0;
    clr_dec();
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");

    // Release: the IDLE cycle shows no request even though memory is ready.
    rst_b = 1;
    #1;
    chk("idle_req", imem_req, 1'b0);
    sb.push_back(32'h100);
    @(negedge clk);
    chk("first_req", imem_req, 1'b1);

    for (int i = 0; i < 10; i++) begin
      fetch(vecs[i].word, vecs[i].gap);
      commit(vecs[i]);
      if (i == 2) chk("count_after_3", retired_count, 32'd3);
    end

    // Memory wait then EXEC stall at 0x2000.
    rcnt = 0;
    imem_ready = 0;
    chk("wait_req", imem_req, 1'b1);
    chk("wait_addr0", imem_addr, sb.pop_front());
    imem_rdata = 32'h0001_1020;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_req_hold", imem_req, 1'b1);
      chk("wait_addr_hold", imem_addr, 32'h2000);
      rcnt += int'(retire);
    end
    imem_ready = 1;
    @(negedge clk);
    chk("stall_enter", instr_valid, 1'b1);
    last_fetch = cyc;
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_pc", pc, 32'h2000);
      chk("stall_instr", instr, 32'h0001_1020);
      chk("stall_valid", instr_valid, 1'b1);
      rcnt += int'(retire);
    end
    stall = 0;
    sb.push_back(32'h2004);
    exp_cnt = exp_cnt + 1;
    @(negedge clk);
    rcnt += int'(retire);
    chk("stall_retires", rcnt, 1);
    chk("stall_count", retired_count, exp_cnt);
    chk("stall_next_pc", pc, 32'h2004);

    // Halt at 0x2004, first held off by a concurrent stall.
    fetch(32'h0000_000C, 1'b0);
    stall = 1; Halted = 1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_over_halt", {halted, instr_valid, retire}, 3'b010);
    end
    stall = 0;
    @(negedge clk);
    Halted = 0;
    chk("halt_flags", {halted, fault, retire}, 3'b100);
    chk("halt_pc", pc, 32'h2004);
    chk("halt_count", retired_count, exp_cnt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_idle", {imem_req, instr_valid}, 2'b00);
    end
    chk("halt_instr_kept", instr, 32'h0000_000C);

    // Misaligned JR target faults after retiring.
    rst_b = 0; #1; rst_b = 1;
    sb.delete(); exp_cnt = 0;
    sb.push_back(32'h100);
    fetch(32'h0020_0008, 1'b0);
    Jump = 1; JumpReg = 1; rs_data = 32'h2002;
    @(negedge clk);
    clr_dec();
    chk("fault_retire", retire, 1'b1);
    chk("fault_count", retired_count, 32'd1);
    chk("fault_pc", pc, 32'h2002);
    chk("fault_flags", {fault, halted, imem_req}, 3'b110);
    @(negedge clk);
    chk("fault_after", {retire, imem_req, instr_valid}, 3'b000);

    // Reset mid-FETCH with the memory answering in the same cycle.
    rst_b = 0; #1; rst_b = 1;
    sb.delete(); exp_cnt = 0;
    sb.push_back(32'h100);
    fetch(32'h0000_0020, 1'b0);
    commit(vecs[0]);
    chk("pre_rst_req", imem_req, 1'b1);
    imem_ready = 1; imem_rdata = 32'hCAFE_F00D;
    #2 rst_b = 0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    chk("rst_instr_held", instr, 32'd0);
    chk("rst_req_held", imem_req, 1'b0);
    rst_b = 1;
    sb.delete(); exp_cnt = 0;
    sb.push_back(32'h100);
    fetch(32'h0000_0020, 1'b0);
    commit(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
